// File: rtl/hispi_psp_pkg.sv
// Shared HiSPi packetized-SP constants: sync codes, sync symbols,
// entry-kind encoding and scheduler states.
package hispi_psp_pkg;

    localparam logic [11:0] CODE_SOL = 12'h001;
    localparam logic [11:0] CODE_SOF = 12'h003;
    localparam logic [11:0] CODE_EOL = 12'h005;
    localparam logic [11:0] CODE_EOF = 12'h007;

    localparam logic [11:0] SYM_PRE0 = 12'hFFF;
    localparam logic [11:0] SYM_PRE1 = 12'h000;

    localparam logic KIND_DATA = 1'b0;
    localparam logic KIND_SYNC = 1'b1;

    localparam int ENTRY_W = 49;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_SYNC = 2'd2
    } sched_e;

    // Symbol for beat 0..3 of a sync sequence, on all four lanes.
    function automatic logic [47:0] sync_beat(
        input logic [1:0]  beat,
        input logic [11:0] code
    );
        logic [11:0] s;
        s = SYM_PRE1;
        if (beat == 2'd0) s = SYM_PRE0;
        if (beat == 2'd3) s = code;
        return {4{s}};
    endfunction

endpackage

// File: rtl/fifo_same_clock.sv
// Single-clock show-ahead FIFO; writes to a full FIFO are dropped.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data, full, empty.
module fifo_same_clock #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en && !full)  wp <= wp + 1'b1;
            if (rd_en && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hispi_psp4l_sequencer.sv
// Packs a 12-bit parallel pixel stream into 4-lane HiSPi PSP beats with
// SOF/SOL/EOL/EOF sync sequences. In: pclk, rst, pxd, vact, hact, clr_err.
// Out: out_valid/out_lanes/out_sync beats, frame_num, line_len, err flags.
module hispi_psp4l_sequencer
    import hispi_psp_pkg::*;
#(
    parameter int MAX_LINE   = 8192,
    parameter int FIFO_DEPTH = 16,
    localparam int LW = $clog2(MAX_LINE) + 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [11:0]   pxd,
    input  logic          vact,
    input  logic          hact,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [47:0]   out_lanes,
    output logic          out_sync,
    output logic [15:0]   frame_num,
    output logic [LW-1:0] line_len,
    output logic          err_align,
    output logic          err_ovfl
);

    logic [11:0]   s0_pxd;
    logic          s0_vact, s0_hact;
    logic          armed, vact_d, line_d;
    logic          vact_v, line_on;
    logic          vact_rise, vact_fall;
    logic          line_rise, line_fall;
    logic          first_line, first_eff;
    logic          pend_eol, pend_eof, pend_sync, pend_sof;
    logic          req_eol, req_eof, req_sync, sof_sel;
    logic [1:0]    lane_q;
    logic [35:0]   grp;
    logic [LW-1:0] pix_cnt;
    logic          ev_full, ev_part, ev_data;
    logic [47:0]   ev_grp;
    logic          push, iss_eol, iss_eof, iss_sync;
    logic [48:0]   push_entry;
    logic          pop, full, empty;
    logic [48:0]   head;
    sched_e        state, state_n;
    logic [1:0]    beat, beat_n;
    logic [11:0]   code_q, code_n;
    logic          valid_n, sync_n;
    logic [47:0]   lanes_n;

    // After reset, vact must be seen low once before a frame is accepted,
    // so a reset mid-frame never produces a bogus SOF or partial line.
    assign vact_v    = s0_vact & armed;
    assign line_on   = vact_v & s0_hact;
    assign vact_rise = vact_v & ~vact_d;
    assign vact_fall = ~vact_v & vact_d;
    assign line_rise = line_on & ~line_d;
    assign line_fall = ~line_on & line_d;
    assign first_eff = first_line | vact_rise;

    assign ev_full = line_on & (lane_q == 2'd3);
    assign ev_part = line_fall & (lane_q != 2'd0);
    assign ev_data = ev_full | ev_part;
    assign ev_grp  = ev_full ? {s0_pxd, grp} : {12'h000, grp};

    assign req_eol  = pend_eol | line_fall;
    assign req_eof  = pend_eof | vact_fall;
    assign req_sync = pend_sync | line_rise;
    assign sof_sel  = pend_sync ? pend_sof : first_eff;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s0_pxd  <= '0;
            s0_vact <= 1'b0;
            s0_hact <= 1'b0;
            armed   <= 1'b0;
            vact_d  <= 1'b0;
            line_d  <= 1'b0;
        end else begin
            s0_pxd  <= pxd;
            s0_vact <= vact;
            s0_hact <= hact;
            armed   <= armed | ~vact;
            vact_d  <= vact_v;
            line_d  <= line_on;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            grp       <= '0;
            pix_cnt   <= '0;
            line_len  <= '0;
            err_align <= 1'b0;
        end else begin
            if (line_on) begin
                if (lane_q == 2'd3) begin
                    grp    <= '0;
                    lane_q <= '0;
                end else begin
                    grp    <= grp | (36'(s0_pxd) << (12 * lane_q));
                    lane_q <= lane_q + 1'b1;
                end
                if (pix_cnt != LW'(MAX_LINE))
                    pix_cnt <= pix_cnt + 1'b1;
            end
            if (line_fall) begin
                grp      <= '0;
                lane_q   <= '0;
                pix_cnt  <= '0;
                line_len <= pix_cnt;
            end
            if (ev_part)      err_align <= 1'b1;
            else if (clr_err) err_align <= 1'b0;
        end
    end

    // One push per cycle; data first, then EOL, EOF, SOF/SOL.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        iss_eol    = 1'b0;
        iss_eof    = 1'b0;
        iss_sync   = 1'b0;
        if (ev_data) begin
            push       = 1'b1;
            push_entry = {KIND_DATA, ev_grp};
        end else if (req_eol) begin
            push       = 1'b1;
            iss_eol    = 1'b1;
            push_entry = {KIND_SYNC, 36'h0, CODE_EOL};
        end else if (req_eof) begin
            push       = 1'b1;
            iss_eof    = 1'b1;
            push_entry = {KIND_SYNC, 36'h0, CODE_EOF};
        end else if (req_sync) begin
            push       = 1'b1;
            iss_sync   = 1'b1;
            push_entry = {KIND_SYNC, 36'h0,
                          sof_sel ? CODE_SOF : CODE_SOL};
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pend_eol   <= 1'b0;
            pend_eof   <= 1'b0;
            pend_sync  <= 1'b0;
            pend_sof   <= 1'b0;
            first_line <= 1'b0;
            frame_num  <= '0;
            err_ovfl   <= 1'b0;
        end else begin
            pend_eol  <= req_eol & ~iss_eol;
            pend_eof  <= req_eof & ~iss_eof;
            pend_sync <= req_sync & ~iss_sync;
            if (line_rise) pend_sof <= first_eff;
            if (line_rise || vact_fall) first_line <= 1'b0;
            else if (vact_rise)         first_line <= 1'b1;
            if (iss_eof) frame_num <= frame_num + 16'd1;
            if (push && full)  err_ovfl <= 1'b1;
            else if (clr_err)  err_ovfl <= 1'b0;
        end
    end

    fifo_same_clock #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_n = state;
        beat_n  = beat;
        code_n  = code_q;
        pop     = 1'b0;
        valid_n = 1'b0;
        sync_n  = 1'b0;
        lanes_n = out_lanes;
        unique case (state)
            ST_IDLE, ST_POP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    valid_n = 1'b1;
                    if (head[48] == KIND_SYNC) begin
                        sync_n  = 1'b1;
                        code_n  = head[11:0];
                        lanes_n = sync_beat(2'd0, head[11:0]);
                        beat_n  = 2'd1;
                        state_n = ST_SYNC;
                    end else begin
                        lanes_n = head[47:0];
                        state_n = ST_POP;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SYNC: begin
                valid_n = 1'b1;
                sync_n  = 1'b1;
                lanes_n = sync_beat(beat, code_q);
                beat_n  = beat + 1'b1;
                if (beat == 2'd3)
                    state_n = empty ? ST_IDLE : ST_POP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            code_q    <= '0;
            out_valid <= 1'b0;
            out_lanes <= '0;
            out_sync  <= 1'b0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            code_q    <= code_n;
            out_valid <= valid_n;
            out_lanes <= lanes_n;
            out_sync  <= sync_n;
        end
    end

endmodule

// File: tb/tb_hispi_psp4l_sequencer.sv
// Directed bench for hispi_psp4l_sequencer: beat sequences, counters,
// error flags and reset behaviour against hand-built expectations.
module tb_hispi_psp4l_sequencer;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pxd = '0;
    logic        vact = 1'b0;
    logic        hact = 1'b0;
    logic        clr_err = 1'b0;
    logic        out_valid;
    logic [47:0] out_lanes;
    logic        out_sync;
    logic [15:0] frame_num;
    logic [13:0] line_len;
    logic        err_align;
    logic        err_ovfl;

    hispi_psp4l_sequencer dut (
        .pclk      (pclk),
        .rst       (rst),
        .pxd       (pxd),
        .vact      (vact),
        .hact      (hact),
        .clr_err   (clr_err),
        .out_valid (out_valid),
        .out_lanes (out_lanes),
        .out_sync  (out_sync),
        .frame_num (frame_num),
        .line_len  (line_len),
        .err_align (err_align),
        .err_ovfl  (err_ovfl)
    );

    always #5 pclk = ~pclk;

    int cyc_cnt = 0;
    always @(posedge pclk) cyc_cnt++;

    logic [48:0] beats[$];
    logic [48:0] expq[$];
    int          tsq[$];

    always @(negedge pclk) begin
        if (out_valid) begin
            beats.push_back({out_sync, out_lanes});
            tsq.push_back(cyc_cnt);
        end
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp, output bit ok);
        ncmp++;
        ok = (obs === exp);
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        bit ok;
        check(tag, obs, exp, ok);
    endtask

    task automatic cmp_seq(input string tag);
        bit ok;
        check({tag, "_len"}, beats.size(), expq.size(), ok);
        for (int i = 0; i < expq.size() && i < beats.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), beats[i], expq[i], ok);
            if (!ok) break;
        end
    endtask

    task automatic clear_q();
        beats.delete();
        tsq.delete();
        expq.delete();
    endtask

    task automatic e_sync(input logic [11:0] code);
        expq.push_back({1'b1, {4{12'hFFF}}});
        expq.push_back({1'b1, 48'h0});
        expq.push_back({1'b1, 48'h0});
        expq.push_back({1'b1, {4{code}}});
    endtask

    task automatic e_data(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d);
        expq.push_back({1'b0, d, c, b, a});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic line(input int n, input int base, input int hb);
        for (int i = 0; i < n; i++) begin
            hact = 1'b1;
            pxd  = 12'(base + i);
            @(negedge pclk);
        end
        hact = 1'b0;
        pxd  = '0;
        cyc(hb);
    endtask

    initial begin
        int t0;
        int n;

        // reset state
        cyc(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_lanes", out_lanes, 0);
        chk("rst_sync", out_sync, 0);
        chk("rst_frame", frame_num, 0);
        chk("rst_linelen", line_len, 0);
        chk("rst_erralign", err_align, 0);
        chk("rst_errovfl", err_ovfl, 0);
        rst = 1'b0;
        cyc(3);

        // one frame, two 8-pixel lines
        clear_q();
        vact = 1'b1;
        cyc(2);
        t0 = cyc_cnt;
        line(8, 1, 8);
        line(8, 9, 8);
        vact = 1'b0;
        cyc(30);
        e_sync(12'h003);
        e_data(1, 2, 3, 4);
        e_data(5, 6, 7, 8);
        e_sync(12'h005);
        e_sync(12'h001);
        e_data(9, 10, 11, 12);
        e_data(13, 14, 15, 16);
        e_sync(12'h005);
        e_sync(12'h007);
        cmp_seq("frame2x8");
        chk("sof_latency", (tsq.size() > 0) ? tsq[0] : -1, t0 + 3);
        chk("frame2x8_fnum", frame_num, 1);
        chk("frame2x8_llen", line_len, 8);
        chk("frame2x8_align", err_align, 0);

        // 6-pixel line: padded last group, alignment error
        clear_q();
        vact = 1'b1;
        cyc(2);
        line(6, 1, 4);
        vact = 1'b0;
        cyc(30);
        e_sync(12'h003);
        e_data(1, 2, 3, 4);
        e_data(5, 6, 0, 0);
        e_sync(12'h005);
        e_sync(12'h007);
        cmp_seq("line6");
        chk("line6_align", err_align, 1);
        chk("line6_llen", line_len, 6);
        chk("line6_fnum", frame_num, 2);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
        chk("clr_align", err_align, 0);

        // hact and vact fall together
        clear_q();
        vact = 1'b1;
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            hact = 1'b1;
            pxd  = 12'(i + 1);
            @(negedge pclk);
        end
        hact = 1'b0;
        vact = 1'b0;
        pxd  = '0;
        cyc(30);
        e_sync(12'h003);
        e_data(1, 2, 3, 4);
        e_data(5, 6, 7, 8);
        e_sync(12'h005);
        e_sync(12'h007);
        cmp_seq("joint_fall");
        n = tsq.size();
        chk("eol_eof_gap", (n >= 8) ? tsq[n-1] - tsq[n-8] : -1, 7);
        chk("joint_fnum", frame_num, 3);
        chk("joint_llen", line_len, 8);

        // 16 lines of 4096 pixels, 1-cycle hblank
        clear_q();
        vact = 1'b1;
        cyc(2);
        for (int ln = 0; ln < 16; ln++) line(4096, ln * 7, 1);
        vact = 1'b0;
        cyc(60);
        for (int ln = 0; ln < 16; ln++) begin
            e_sync(ln == 0 ? 12'h003 : 12'h001);
            for (int g = 0; g < 1024; g++)
                e_data(12'(ln * 7 + 4 * g), 12'(ln * 7 + 4 * g + 1),
                       12'(ln * 7 + 4 * g + 2), 12'(ln * 7 + 4 * g + 3));
            e_sync(12'h005);
        end
        e_sync(12'h007);
        cmp_seq("burst");
        chk("burst_ovfl", err_ovfl, 0);
        chk("burst_llen", line_len, 4096);
        chk("burst_fnum", frame_num, 4);

        // reset mid-line at pixel 100
        vact = 1'b1;
        cyc(2);
        for (int i = 0; i < 100; i++) begin
            hact = 1'b1;
            pxd  = 12'(i + 1);
            @(negedge pclk);
        end
        rst = 1'b1;
        @(negedge pclk);
        chk("mid_valid", out_valid, 0);
        chk("mid_lanes", out_lanes, 0);
        chk("mid_sync", out_sync, 0);
        chk("mid_fnum", frame_num, 0);
        chk("mid_llen", line_len, 0);
        chk("mid_ovfl", err_ovfl, 0);
        cyc(1);
        rst = 1'b0;
        clear_q();
        for (int i = 0; i < 20; i++) begin
            pxd = 12'(i + 101);
            @(negedge pclk);
        end
        hact = 1'b0;
        cyc(5);
        line(8, 50, 4);
        vact = 1'b0;
        cyc(10);
        cmp_seq("after_rst_quiet");
        clear_q();
        vact = 1'b1;
        cyc(2);
        line(4, 1, 4);
        vact = 1'b0;
        cyc(30);
        e_sync(12'h003);
        e_data(1, 2, 3, 4);
        e_sync(12'h005);
        e_sync(12'h007);
        cmp_seq("after_rst_frame");
        chk("after_rst_fnum", frame_num, 1);
        chk("after_rst_llen", line_len, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
